// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//   booth_state_e : control FSM states
//   booth_digit_e : decoded Booth digit for one multiplier triplet
//   booth_iter()  : number of radix-4 steps for a given width and mode
package booth_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadQ,
    StCalc,
    StOutLo,
    StOutHi
  } booth_state_e;

  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } booth_digit_e;

  // Unsigned operands need one extra step so the top multiplier bit is
  // treated as a positive weight rather than a sign bit.
  function automatic int unsigned booth_iter(input int unsigned width, input logic signed_mode);
    return signed_mode ? (width / 2) : (width / 2 + 1);
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder (combinational).
//   triplet_i : {q[2i+1], q[2i], q[2i-1]} multiplier bits
//   m_ext_i   : multiplicand, already extended to WIDTH+2 bits (two's complement)
//   pp_o      : signed partial product (0, +-M, +-2M) on WIDTH+3 bits
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       triplet_i,
  input  logic [WIDTH+1:0] m_ext_i,
  output logic [WIDTH+2:0] pp_o
);

  booth_digit_e     digit;
  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;

  assign m1 = {m_ext_i[WIDTH+1], m_ext_i};
  assign m2 = {m_ext_i, 1'b0};

  always_comb begin
    digit = ZERO;
    case (triplet_i)
      3'b000, 3'b111: digit = ZERO;
      3'b001, 3'b010: digit = PM;
      3'b011:         digit = P2M;
      3'b100:         digit = N2M;
      3'b101, 3'b110: digit = NM;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    pp_o = '0;
    unique case (digit)
      ZERO:    pp_o = '0;
      PM:      pp_o = m1;
      P2M:     pp_o = m2;
      NM:      pp_o = -m1;
      N2M:     pp_o = -m2;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul.sv
// Radix-4 Booth multiplier, signed or unsigned, with serial operand load.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   enable      : start pulse, inbus carries M in the same cycle (IDLE only)
//   signed_mode : 1 = two's complement, 0 = unsigned; sampled with M
//   inbus       : M in the enable cycle, Q in the following cycle
//   outbus      : product low half (OUT_LO) then high half (OUT_HI), else 0
//   done        : high during both output beats
//   busy        : high from M capture until the last output beat
module booth_r4_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             done,
  output logic             busy
);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : gen_bad_width
    $error("booth_r4_mul: WIDTH must be even and >= 4");
  end

  localparam int unsigned AccW = 2 * WIDTH + 4;
  localparam int unsigned QW   = WIDTH + 3;
  localparam int unsigned MW   = WIDTH + 2;
  localparam int unsigned CntW = $clog2(WIDTH / 2 + 2);

  booth_state_e    state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic            sm_q, sm_d;
  logic [QW-1:0]   q_q, q_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [CntW-1:0] cnt_last;
  logic [QW-1:0]   pp;
  logic [AccW-1:0] pp_ext;
  logic            unused_acc;

  // The mode is latched with M so a mid-operation change cannot alter the step count.
  assign cnt_last = CntW'(booth_iter(WIDTH, sm_q) - 1);

  booth_r4_encoder #(
    .WIDTH(WIDTH)
  ) u_enc (
    .triplet_i(q_q[2:0]),
    .m_ext_i  (m_q),
    .pp_o     (pp)
  );

  assign pp_ext     = {{(AccW - QW){pp[QW-1]}}, pp};
  assign unused_acc = ^acc_q[AccW-1:2*WIDTH];

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      m_q     <= '0;
      sm_q    <= 1'b0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      sm_q    <= sm_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StLoadQ;
      StLoadQ: state_d = StCalc;
      StCalc:  if (cnt_q == cnt_last) state_d = StOutLo;
      StOutLo: state_d = StOutHi;
      StOutHi: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    m_d   = m_q;
    sm_d  = sm_q;
    q_d   = q_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          m_d  = signed_mode ? {{2{inbus[WIDTH-1]}}, inbus} : {2'b00, inbus};
          sm_d = signed_mode;
        end
      end
      StLoadQ: begin
        // Implicit 0 below bit 0; unsigned mode zero-fills the two guard bits on top.
        q_d   = {(sm_q ? {2{inbus[WIDTH-1]}} : 2'b00), inbus, 1'b0};
        acc_d = '0;
        cnt_d = '0;
      end
      StCalc: begin
        // Partial product for step i lands at weight 4^i.
        acc_d = acc_q + (pp_ext << {cnt_q, 1'b0});
        q_d   = q_q >> 2;
        cnt_d = cnt_q + CntW'(1);
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    outbus = '0;
    done   = 1'b0;
    busy   = (state_q != StIdle);
    unique case (state_q)
      StOutLo: begin
        done   = 1'b1;
        outbus = acc_q[WIDTH-1:0];
      end
      StOutHi: begin
        done   = 1'b1;
        outbus = acc_q[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul: an 8-bit and a 16-bit instance,
// expected products queued at stimulus time and compared at the output beats.
module tb_booth_r4_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en8, sm8, done8, busy8;
  logic [7:0]  in8, out8;
  logic        en16, sm16, done16, busy16;
  logic [15:0] in16, out16;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] sb8[$];
  logic [31:0] sb16[$];

  booth_r4_mul #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en8),
    .signed_mode(sm8),
    .inbus      (in8),
    .outbus     (out8),
    .done       (done8),
    .busy       (busy8)
  );

  booth_r4_mul #(.WIDTH(16)) u_dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en16),
    .signed_mode(sm16),
    .inbus      (in16),
    .outbus     (out16),
    .done       (done16),
    .busy       (busy16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain integer product of the operands interpreted in the requested mode.
  function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q,
                                          input logic sm, input int w);
    longint a, b;
    a = longint'(m);
    b = longint'(q);
    if (sm && m[w-1]) a = a - (longint'(1) << w);
    if (sm && q[w-1]) b = b - (longint'(1) << w);
    return 32'(a * b);
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the first IDLE cycle.
  task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic sm, input bit noisy);
    int          edges;
    logic [31:0] full;
    logic [15:0] exp;
    full = ref_mul({8'h00, m}, {8'h00, q}, sm, 8);
    sb8.push_back(full[15:0]);
    en8 = 1'b1;
    sm8 = sm;
    in8 = m;
    @(posedge clk);
    #1 check_eq("busy8_after_e0", 64'(busy8), 64'(1));
    @(negedge clk);
    en8   = 1'b0;
    in8   = q;
    sm8   = ~sm;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      in8 = 8'($urandom);
      if (noisy) en8 = 1'($urandom);
    end while (!done8 && edges < 40);
    if (!done8) begin
      check_eq("done8_timeout", 64'(done8), 64'(1));
      void'(sb8.pop_front());
      en8 = 1'b0;
      return;
    end
    check_eq("latency8", 64'(edges), 64'(sm ? 5 : 6));
    exp = sb8.pop_front();
    check_eq("lo8", 64'(out8), 64'(exp[7:0]));
    if (noisy) begin
      en8 = 1'b1;
      in8 = 8'($urandom);
    end
    @(negedge clk);
    check_eq("done8_hi", 64'(done8), 64'(1));
    check_eq("hi8", 64'(out8), 64'(exp[15:8]));
    en8 = 1'b0;
    @(negedge clk);
    check_eq("idle8_done", 64'(done8), 64'(0));
    check_eq("idle8_busy", 64'(busy8), 64'(0));
    check_eq("idle8_out", 64'(out8), 64'(0));
  endtask

  task automatic op16(input logic [15:0] m, input logic [15:0] q, input logic sm);
    int          edges;
    logic [31:0] exp;
    sb16.push_back(ref_mul(m, q, sm, 16));
    en16 = 1'b1;
    sm16 = sm;
    in16 = m;
    @(negedge clk);
    en16  = 1'b0;
    in16  = q;
    sm16  = ~sm;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      in16 = 16'($urandom);
    end while (!done16 && edges < 60);
    if (!done16) begin
      check_eq("done16_timeout", 64'(done16), 64'(1));
      void'(sb16.pop_front());
      return;
    end
    check_eq("latency16", 64'(edges), 64'(sm ? 9 : 10));
    exp = sb16.pop_front();
    check_eq("lo16", 64'(out16), 64'(exp[15:0]));
    @(negedge clk);
    check_eq("hi16", 64'(out16), 64'(exp[31:16]));
    @(negedge clk);
    check_eq("idle16_busy", 64'(busy16), 64'(0));
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    en8   = 1'b0;
    sm8   = 1'b0;
    in8   = '0;
    en16  = 1'b0;
    sm16  = 1'b0;
    in16  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_out8", 64'(out8), 64'(0));
    check_eq("rst_done8", 64'(done8), 64'(0));
    check_eq("rst_busy8", 64'(busy8), 64'(0));
    check_eq("rst_out16", 64'(out16), 64'(0));
    check_eq("rst_busy16", 64'(busy16), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic signed/unsigned and corner products.
    op8(8'hFD, 8'h05, 1'b1, 1'b0);
    op8(8'hFD, 8'h05, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0, 1'b0);
    op8(8'h80, 8'h80, 1'b1, 1'b0);
    op8(8'h7F, 8'h80, 1'b1, 1'b0);
    op8(8'hA5, 8'h00, 1'b1, 1'b0);
    op8(8'hA5, 8'h00, 1'b0, 1'b0);

    // Spurious enables in flight, then a back-to-back start.
    op8(8'hFD, 8'h05, 1'b1, 1'b1);
    op8(8'h06, 8'h07, 1'b1, 1'b0);

    // Reset in the middle of CALC.
    en8 = 1'b1;
    sm8 = 1'b1;
    in8 = 8'h55;
    @(negedge clk);
    en8 = 1'b0;
    in8 = 8'h33;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy8", 64'(busy8), 64'(0));
    check_eq("midrst_done8", 64'(done8), 64'(0));
    check_eq("midrst_out8", 64'(out8), 64'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    check_eq("no_beats_after_reset", 64'(saw_done), 64'(0));
    op8(8'h02, 8'h03, 1'b1, 1'b0);

    // Wide instance: corners then random pairs in both modes.
    op16(16'h8000, 16'h8000, 1'b1);
    op16(16'hFFFF, 16'hFFFF, 1'b0);
    op16(16'h7FFF, 16'h8000, 1'b1);
    for (int i = 0; i < 200; i++) begin
      op16(16'($urandom), 16'($urandom), 1'(i % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
